// File: rtl/reg_file.sv
// 32 x DATA_W register file with two combinational read ports, one write port,
// r0 hardwired to zero, and a post-reset clear sequencer for the non-resettable array.
module reg_file #(
    parameter int DATA_W = 32,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite,
    input  logic [4:0]        WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [4:0]        ReadReg1,
    input  logic [4:0]        ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic              busy
);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state_q;
    logic [4:0]        clrIdx_q;
    logic              busy_q;

    logic [DATA_W-1:0] regArray_q [0:31];

    logic              wrEn_d;
    logic [4:0]        wrAddr_d;
    logic [DATA_W-1:0] wrData_d;

    // Clear sequencer: one register per edge, then hand the array to the CPU.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CLEAR;
            clrIdx_q <= 5'd1;
            busy_q   <= 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    clrIdx_q <= clrIdx_q + 5'd1;
                    if (clrIdx_q == 5'd31) begin
                        state_q <= RUN;
                        busy_q  <= 1'b0;
                    end
                end
                RUN: begin
                    state_q <= RUN;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= CLEAR;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    // Single write port shared by the sequencer and the CPU so the array maps to distributed RAM.
    always_comb begin
        wrEn_d   = 1'b0;
        wrAddr_d = WriteReg;
        wrData_d = WriteData;
        if (!rst) begin
            if (state_q == CLEAR) begin
                wrEn_d   = 1'b1;
                wrAddr_d = clrIdx_q;
                wrData_d = '0;
            end else if (RegWrite && (WriteReg != 5'd0)) begin
                wrEn_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn_d) begin
            regArray_q[wrAddr_d] <= wrData_d;
        end
    end

    // r0 and the clear window read as zero; forwarding only when BYPASS is enabled.
    always_comb begin
        ReadData1 = regArray_q[ReadReg1];
        if (ReadReg1 == 5'd0 || busy_q) begin
            ReadData1 = '0;
        end else if (BYPASS != 0 && RegWrite && WriteReg == ReadReg1) begin
            ReadData1 = WriteData;
        end
    end

    always_comb begin
        ReadData2 = regArray_q[ReadReg2];
        if (ReadReg2 == 5'd0 || busy_q) begin
            ReadData2 = '0;
        end else if (BYPASS != 0 && RegWrite && WriteReg == ReadReg2) begin
            ReadData2 = WriteData;
        end
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; a BYPASS=1 and a BYPASS=0 instance share all inputs.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [31:0] rdA1, rdA2, rdB1, rdB2;
    logic        busyA, busyB;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;
    int edgeCount;

    reg_file #(.DATA_W(32), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .RegWrite(RegWrite), .WriteReg(WriteReg),
        .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(rdA1), .ReadData2(rdA2), .busy(busyA)
    );

    reg_file #(.DATA_W(32), .BYPASS(0)) dutNoBypass (
        .clk(clk), .rst(rst), .RegWrite(RegWrite), .WriteReg(WriteReg),
        .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(rdB1), .ReadData2(rdB2), .busy(busyB)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic [4:0] ra1, input logic [4:0] ra2);
        RegWrite  = we;
        WriteReg  = wa;
        WriteData = wd;
        ReadReg1  = ra1;
        ReadReg2  = ra2;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd3);
        tick();
        tick();
        rst = 1'b0;
        #1;
        checkOutput("busy_after_reset", {31'b0, busyA}, 32'd1);
        checkOutput("busy_after_reset_nb", {31'b0, busyB}, 32'd1);
        checkOutput("r5_after_reset", rdA1, 32'h0);

        // Clear window, with a write attempt on clear edge 10 that must be dropped.
        for (int i = 1; i <= 31; i++) begin
            if (i == 10) begin
                applyStimulus(1'b1, 5'd3, 32'hAAAA5555, 5'd5, 5'd3);
                checkOutput("r3_bypass_gated_busy", rdA2, 32'h0);
            end
            tick();
            applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd3);
            if (i < 31) begin
                checkOutput("busy_during_clear", {31'b0, busyA}, 32'd1);
                checkOutput("r5_during_clear", rdA1, 32'h0);
            end else begin
                checkOutput("busy_after_clear", {31'b0, busyA}, 32'd0);
                checkOutput("busy_after_clear_nb", {31'b0, busyB}, 32'd0);
            end
        end
        checkOutput("r5_after_clear", rdA1, 32'h0);
        checkOutput("r3_write_dropped", rdA2, 32'h0);
        checkOutput("r3_write_dropped_nb", rdB2, 32'h0);

        // Basic writes; r9 read during its own write exercises forwarding.
        applyStimulus(1'b1, 5'd8, 32'h12345678, 5'd8, 5'd9);
        tick();
        applyStimulus(1'b1, 5'd9, 32'hDEADBEEF, 5'd8, 5'd9);
        checkOutput("r9_bypass", rdA2, 32'hDEADBEEF);
        checkOutput("r9_nobypass_old", rdB2, 32'h0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd8, 5'd9);
        checkOutput("r8_read", rdA1, 32'h12345678);
        checkOutput("r9_read", rdA2, 32'hDEADBEEF);
        checkOutput("r8_read_nb", rdB1, 32'h12345678);
        checkOutput("r9_read_nb", rdB2, 32'hDEADBEEF);

        // Same register on both ports.
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd8, 5'd8);
        checkOutput("same_reg_p2", rdA2, 32'h12345678);

        // Register 0 is hardwired.
        applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        checkOutput("r0_same_cycle", rdA1, 32'h0);
        checkOutput("r0_same_cycle_p2", rdA2, 32'h0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        checkOutput("r0_next_cycle", rdA1, 32'h0);
        checkOutput("r0_next_cycle_nb", rdB1, 32'h0);

        // Forwarding on r31 (link register).
        applyStimulus(1'b1, 5'd31, 32'h00400008, 5'd0, 5'd31);
        checkOutput("r31_bypass", rdA2, 32'h00400008);
        checkOutput("r31_nobypass_old", rdB2, 32'h0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd31);
        checkOutput("r31_after_edge", rdA2, 32'h00400008);
        checkOutput("r31_after_edge_nb", rdB2, 32'h00400008);

        // Back-to-back writes to one register: last wins.
        applyStimulus(1'b1, 5'd8, 32'h00000001, 5'd8, 5'd0);
        tick();
        applyStimulus(1'b1, 5'd8, 32'h00000002, 5'd8, 5'd0);
        checkOutput("b2b_nobypass_mid", rdB1, 32'h00000001);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd8, 5'd0);
        checkOutput("b2b_last_wins", rdA1, 32'h00000002);
        checkOutput("b2b_last_wins_nb", rdB1, 32'h00000002);

        // Fill r1..r31 with their index, then reset mid-run.
        for (int r = 1; r <= 31; r++) begin
            applyStimulus(1'b1, 5'(r), 32'(r), 5'd0, 5'd0);
            tick();
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd1, 5'd31);
        checkOutput("fill_r1", rdA1, 32'd1);
        checkOutput("fill_r31", rdA2, 32'd31);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd17, 5'd30);
        checkOutput("fill_r17_nb", rdB1, 32'd17);
        checkOutput("fill_r30_nb", rdB2, 32'd30);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checkOutput("busy_midrun_reset", {31'b0, busyA}, 32'd1);
        checkOutput("r17_zero_while_busy", rdA1, 32'h0);
        edgeCount = 0;
        for (int i = 0; i < 40 && busyA; i++) begin
            tick();
            edgeCount++;
        end
        checkOutput("midrun_clear_length", 32'(edgeCount), 32'd31);
        checkOutput("busy_nb_after_midrun", {31'b0, busyB}, 32'd0);

        for (int r = 1; r <= 31; r++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 5'(r), 5'(32 - r));
            checkOutput("cleared_p1", rdA1, 32'h0);
            checkOutput("cleared_p2", rdA2, 32'h0);
            checkOutput("cleared_p1_nb", rdB1, 32'h0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/reg_file.md
# reg_file

Register file for the multicycle CPU datapath, directly downstream of the RegDst destination mux. Its write address is the mux's 5-bit output (rt, rd or 31). It holds 32 general registers, serves two combinational read ports and one clocked write port, and keeps register 0 hardwired to zero. After reset it runs a 31-cycle hardware clear sequencer, because the array maps to distributed RAM, which has no bulk reset. It reports `busy` until the clear completes.

## Interface
Parameters:
- `DATA_W`, default 32: register width in bits.
- `BYPASS`, default 1: 1 = write-through forwarding on the read ports; 0 = reads show the pre-edge array contents.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `RegWrite`, input, 1: write enable, sampled at the rising edge.
- `WriteReg`, input, 5: destination register number, driven by the RegDst mux output.
- `WriteData`, input, DATA_W: data to write.
- `ReadReg1`, input, 5: read port 1 address (rs).
- `ReadReg2`, input, 5: read port 2 address (rt).
- `ReadData1`, output, DATA_W: read port 1 data, combinational.
- `ReadData2`, output, DATA_W: read port 2 data, combinational.
- `busy`, output, 1: high while the clear sequence runs; a registered output.

## Operation
- State machine has two states: CLEAR and RUN. It holds a 5-bit clear index `clr_idx`.
- Edge with `rst`=1 → state CLEAR, `clr_idx`=1, from any state and regardless of other inputs. Array contents are not touched on that edge.
- CLEAR edge with `rst`=0:
  - reg[`clr_idx`] ← 0; `clr_idx` ← `clr_idx`+1.
  - When `clr_idx`==31, the next state is RUN.
  - `RegWrite` is ignored: the write is dropped, not queued.
- RUN edge with `RegWrite`=1 and `WriteReg`≠0 → reg[`WriteReg`] ← `WriteData`.
  - Writes to register 0 are discarded.
  - RUN persists until the next `rst`.
- `busy` = (state==CLEAR). It is asserted from the first `rst` edge until the 31st clearing edge.
- Read ports, independently for port n (1 or 2):
  - If `ReadRegn`==0 → 0.
  - Else if `busy` → 0. Contents are not yet defined.
  - Else if `BYPASS`=1, `RegWrite`=1 and `WriteReg`==`ReadRegn` → `WriteData`.
  - Else → reg[`ReadRegn`].
- Both ports may address the same register; both return the same value.
- Reset mid-clear restarts the sequence at `clr_idx`=1. Registers already cleared stay 0.
- Reset mid-operation, i.e. during RUN, restarts the full clear. Every register returns to 0 after the sequence.

## Timing
- Output reset values:
  - `busy`=1 after the first `rst` edge.
  - `ReadData1`/`ReadData2`=0 while `busy`.
  - Before the first `rst` edge, state is undefined; the CPU top guarantees `rst` at power-up.
- Clear length: with `rst` high for edge k and low from edge k+1, registers 1..31 are cleared on edges k+1..k+31. `busy` falls after edge k+31. The first accepted write is at edge k+32.
- Write latency: data is visible through the array on the cycle after the write edge. With `BYPASS`=1 it is also visible in the same cycle, before the edge.
- Read path is purely combinational from `ReadRegn`, `WriteReg`, `RegWrite`, `WriteData` and the array. There is no read latency.
- Simultaneous write and read of the same register at an edge: the read before the edge sees `WriteData` (`BYPASS`=1) or the old value (`BYPASS`=0). After the edge, both settings see `WriteData`.
- Back-to-back writes to the same register on consecutive edges: the last write wins; no stall.

## Test plan
- Reset sequence: hold `rst`=1 for 2 edges, then release → `busy`=1 for exactly 31 edges, then 0. `ReadData1` for `ReadReg1`=5 reads 0 throughout and after.
- Basic write/read: write 0x12345678 to r8 and 0xDEADBEEF to r9 → next cycle `ReadData1`(r8)=0x12345678 and `ReadData2`(r9)=0xDEADBEEF.
- Register 0: `RegWrite`=1, `WriteReg`=0, `WriteData`=0xFFFFFFFF → `ReadData1`(r0)=0 in the same cycle and the next cycle.
- Bypass: `RegWrite`=1, `WriteReg`=31, `WriteData`=0x00400008, `ReadReg2`=31 → `ReadData2`=0x00400008 before the edge with `BYPASS`=1. With `BYPASS`=0 it shows the old value (0 after reset).
- Write during clear: `RegWrite`=1, `WriteReg`=3, `WriteData`=0xAAAA5555 on clear edge 10 → dropped; r3 reads 0 after `busy` falls.
- Reset mid-run: fill r1..r31 with their index, assert `rst` for one edge → `busy` for 31 edges; afterwards every register reads 0.
